// File: rtl/systolic_output_requant.sv
// Requantises 32-lane result beats (bias add, arithmetic shift, optional ReLU, saturate). Latency is 2 cycles.
// Backpressure stalls both register stages; st_in_ready drops only when the two stages are full and the output is held.
module systolic_output_requant #(
    parameter int LANES  = 32,
    parameter int IN_W   = 8,
    parameter int OUT_W  = 8,
    parameter int BIAS_W = 16,
    parameter int CNT_W  = 12
) (
    input  logic                     clock_sink,
    input  logic                     reset_sink_reset,
    input  logic [7:0]               csr_address,
    input  logic                     csr_write,
    input  logic [31:0]              csr_writedata,
    input  logic                     csr_read,
    output logic [31:0]              csr_readdata,
    input  logic [LANES*IN_W-1:0]    st_in_data,
    input  logic                     st_in_valid,
    output logic                     st_in_ready,
    output logic [LANES*OUT_W-1:0]   st_out_data,
    output logic                     st_out_valid,
    input  logic                     st_out_ready,
    output logic                     st_out_endofpacket
);
    localparam int SW = ((IN_W > BIAS_W) ? IN_W : BIAS_W) + 1;
    localparam logic signed [SW-1:0] OMAX = {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [SW-1:0] OMIN = {{(SW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic                      sh_relu, act_relu;
    logic [3:0]                sh_shift, act_shift;
    logic signed [BIAS_W-1:0]  sh_bias, act_bias;
    logic [CNT_W-1:0]          sh_beats, act_beats;
    logic [CNT_W-1:0]          beat_cnt;
    logic [15:0]               tiles_done;

    logic                      s1_valid, s1_relu, s1_last;
    logic [LANES-1:0][SW-1:0]  s1_t, s1_t_nxt;
    logic                      s2_valid, s2_last;
    logic [LANES*OUT_W-1:0]    s2_dat, s2_nxt;

    logic                      s2_load, s1_adv, in_fire, first_beat, beat_last;
    logic                      cur_relu;
    logic [3:0]                cur_shift;
    logic signed [BIAS_W-1:0]  cur_bias;
    logic [CNT_W-1:0]          cur_beats, cur_len;
    logic [31:0]               rd_mux;

    assign s2_load     = !s2_valid || st_out_ready;
    assign s1_adv      = s2_load || !s1_valid;
    assign st_in_ready = s1_adv;
    assign in_fire     = st_in_valid && st_in_ready;

    // The first beat of a tile sees the shadow config directly; the same edge copies it into the active set.
    assign first_beat = (beat_cnt == '0);
    assign cur_relu   = first_beat ? sh_relu  : act_relu;
    assign cur_shift  = first_beat ? sh_shift : act_shift;
    assign cur_bias   = first_beat ? sh_bias  : act_bias;
    assign cur_beats  = first_beat ? sh_beats : act_beats;
    assign cur_len    = (cur_beats == '0) ? CNT_W'(1) : cur_beats;
    assign beat_last  = (beat_cnt == cur_len - CNT_W'(1));

    always_comb begin
        s1_t_nxt = '0;
        for (int k = 0; k < LANES; k++) begin
            logic signed [IN_W-1:0] lane_x;
            logic signed [SW-1:0]   lane_s;
            lane_x = $signed(st_in_data[k*IN_W +: IN_W]);
            lane_s = SW'(lane_x) + SW'(cur_bias);
            s1_t_nxt[k] = lane_s >>> cur_shift;
        end
    end

    always_comb begin
        s2_nxt = '0;
        for (int k = 0; k < LANES; k++) begin
            logic signed [SW-1:0] t;
            t = $signed(s1_t[k]);
            if (s1_relu && t < 0)
                t = '0;
            if (t > OMAX)
                s2_nxt[k*OUT_W +: OUT_W] = OMAX[OUT_W-1:0];
            else if (t < OMIN)
                s2_nxt[k*OUT_W +: OUT_W] = OMIN[OUT_W-1:0];
            else
                s2_nxt[k*OUT_W +: OUT_W] = t[OUT_W-1:0];
        end
    end

    always_ff @(posedge clock_sink) begin
        if (reset_sink_reset) begin
            s1_valid <= 1'b0;
            s1_relu  <= 1'b0;
            s1_last  <= 1'b0;
            s1_t     <= '0;
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_dat   <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_fire;
                if (in_fire) begin
                    s1_t    <= s1_t_nxt;
                    s1_relu <= cur_relu;
                    s1_last <= beat_last;
                end
            end
            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_dat  <= s2_nxt;
                    s2_last <= s1_last;
                end
            end
        end
    end

    assign st_out_valid       = s2_valid;
    assign st_out_data        = s2_dat;
    assign st_out_endofpacket = s2_valid && s2_last;

    always_ff @(posedge clock_sink) begin
        if (reset_sink_reset) begin
            sh_relu    <= 1'b0;
            sh_shift   <= '0;
            sh_bias    <= '0;
            sh_beats   <= CNT_W'(32);
            act_relu   <= 1'b0;
            act_shift  <= '0;
            act_bias   <= '0;
            act_beats  <= CNT_W'(32);
            beat_cnt   <= '0;
            tiles_done <= '0;
        end else begin
            if (in_fire) begin
                beat_cnt <= beat_last ? '0 : beat_cnt + CNT_W'(1);
                if (first_beat) begin
                    act_relu  <= sh_relu;
                    act_shift <= sh_shift;
                    act_bias  <= sh_bias;
                    act_beats <= sh_beats;
                end
            end
            if (s2_valid && st_out_ready && s2_last)
                tiles_done <= tiles_done + 16'd1;
            if (csr_write) begin
                case (csr_address)
                    8'd0: begin
                        sh_relu  <= csr_writedata[0];
                        sh_shift <= csr_writedata[11:8];
                    end
                    8'd1:    sh_bias  <= csr_writedata[BIAS_W-1:0];
                    8'd2:    sh_beats <= csr_writedata[CNT_W-1:0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (csr_address)
            8'd0: begin
                rd_mux[11:8] = sh_shift;
                rd_mux[0]    = sh_relu;
            end
            8'd1: rd_mux[BIAS_W-1:0] = sh_bias;
            8'd2: rd_mux[CNT_W-1:0]  = sh_beats;
            8'd3: begin
                rd_mux[31:16]       = tiles_done;
                rd_mux[CNT_W-1:0]   = beat_cnt;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock_sink) begin
        if (reset_sink_reset)
            csr_readdata <= '0;
        else
            csr_readdata <= csr_read ? rd_mux : 32'd0;
    end
endmodule
